// File: rtl/mem_pkg.sv
// Shared memory-access definitions: the decode-stage parameter bundle,
// access-size codes and the load/store unit state encoding.
package mem_pkg;

    typedef struct packed {
        logic       op;             // 1=read, 0=write
        logic [1:0] access_size;
        logic       read_unsigned;
    } mem_params_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned data bus with a req/ack handshake.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables, store replication, load
// extraction/extension and the alignment fault check.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        read_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {off, 3'b000};
        byte_en   = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;
        fault     = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << off;
                wdata     = {4{store_data[7:0]}};
                load_data = read_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_en   = 4'b0011 << off;
                wdata     = {2{store_data[15:0]}};
                load_data = read_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
                fault     = off[0];
            end
            SIZE_WORD: begin
                byte_en   = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
                fault     = (off != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute-side load/store stage: one bus transaction per access, with
// alignment fault detection, bus timeout and extended load return.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  mem_params_t               mem_params,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               load_data,
    output logic                      misaligned,
    output logic                      bus_error,
    load_store_unit_if.master         bus
);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      sd_q, sd_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             misaligned_q, misaligned_d;
    logic             bus_error_q, bus_error_d;

    logic             in_idle, in_req, timeout_hit;
    logic [1:0]       al_size, al_off;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata, al_load;
    logic             al_fault;

    assign in_idle = (state_q == IDLE);
    assign in_req  = (state_q == REQ);

    // In IDLE the aligner checks the incoming request for faults; afterwards
    // it works from the captured request to drive the bus and extract loads.
    assign al_size = in_idle ? mem_params.access_size : size_q;
    assign al_off  = in_idle ? addr[1:0] : addr_q[1:0];

    mem_align u_align (
        .size          (al_size),
        .read_unsigned (uns_q),
        .off           (al_off),
        .store_data    (sd_q),
        .rdata         (bus.bus_rdata),
        .byte_en       (al_be),
        .wdata         (al_wdata),
        .load_data     (al_load),
        .fault         (al_fault)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        sd_d         = sd_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        bus_error_d  = bus_error_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    op_d         = mem_params.op;
                    size_d       = mem_params.access_size;
                    uns_d        = mem_params.read_unsigned;
                    addr_d       = addr;
                    sd_d         = store_data;
                    load_data_d  = 32'h0;
                    bus_error_d  = 1'b0;
                    misaligned_d = al_fault;
                    state_d      = al_fault ? DONE : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // ack takes priority over a timeout landing in the same cycle
                if (bus.bus_ack) begin
                    load_data_d = op_q ? al_load : 32'h0;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            sd_q         <= 32'h0;
            load_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            sd_q         <= sd_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign busy       = !in_idle;
    assign done       = (state_q == DONE);
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign bus_error  = bus_error_q;

    // Bus outputs are decoded from state so reset drops them immediately.
    assign bus.bus_req     = in_req;
    assign bus.bus_we      = in_req & ~op_q;
    assign bus.bus_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.bus_byte_en = in_req ? al_be : 4'b0000;
    assign bus.bus_wdata   = in_req ? al_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed checks of load_store_unit against a byte-lane
// reference model.
module tb_load_store_unit;
    import mem_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    mem_params_t mp = '0;
    logic [31:0] addr = 32'h0;
    logic [31:0] sd = 32'h0;
    logic        busy, done, misaligned, bus_error;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    load_store_unit_if bif ();

    load_store_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .mem_params (mp),
        .addr       (addr),
        .store_data (sd),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Lane-by-lane reference: n = access bytes, lanes off..off+n-1 active.
    function automatic void model(input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rd, output logic flt,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int n, off;
        logic [31:0] mask;
        off = int'(a[1:0]);
        n   = (sz == 2'b11) ? 0 : (1 << sz);
        flt = (n == 0) || ((off % n) != 0);
        be = 4'b0; wd = 32'h0; ld = 32'h0;
        if (!flt) begin
            for (int i = 0; i < 4; i++) begin
                be[i] = (i >= off) && (i < off + n);
                wd[8*i +: 8] = d[8*(i % n) +: 8];
            end
            ld = rd >> (8 * off);
            if (n < 4) begin
                mask = (32'h1 << (8 * n)) - 32'h1;
                ld = ld & mask;
                if (!uns && ld[8*n-1]) ld = ld | ~mask;
            end
        end
    endfunction

    task automatic access(input logic op, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input int dly, input logic [31:0] rd);
        logic flt;
        logic [3:0] be;
        logic [31:0] wd, ld, exp_ld;
        logic exp_err;
        bit acked;
        int k;
        model(sz, uns, a, d, rd, flt, be, wd, ld);
        @(negedge clk);
        start = 1'b1; mp.op = op; mp.access_size = sz; mp.read_unsigned = uns;
        addr = a; sd = d;
        @(negedge clk);
        start = 1'b0;
        exp_ld = 32'h0; exp_err = 1'b0;
        if (flt) begin
            chk("fault_no_req", {31'h0, bif.bus_req}, 32'h0);
            chk("fault_done", {31'h0, done}, 32'h1);
            chk("fault_mis", {31'h0, misaligned}, 32'h1);
        end else begin
            k = 0; acked = 0;
            forever begin
                chk("req", {31'h0, bif.bus_req}, 32'h1);
                chk("we", {31'h0, bif.bus_we}, {31'h0, !op});
                chk("addr", bif.bus_addr, {a[31:2], 2'b00});
                chk("be", {28'h0, bif.bus_byte_en}, {28'h0, be});
                chk("wdata", bif.bus_wdata, wd);
                chk("done_low", {31'h0, done}, 32'h0);
                // scramble the request inputs: they must be ignored mid-access
                start = 1'($urandom_range(0, 1));
                addr = $urandom; sd = $urandom;
                mp = mem_params_t'(4'($urandom_range(0, 15)));
                if (k == dly) begin
                    bif.bus_ack = 1'b1; bif.bus_rdata = rd; acked = 1;
                end else begin
                    bif.bus_rdata = $urandom;
                end
                @(negedge clk);
                bif.bus_ack = 1'b0; start = 1'b0;
                if (acked || k == T - 1) break;
                k++;
            end
            exp_err = !acked;
            exp_ld  = (acked && op) ? ld : 32'h0;
            chk("done", {31'h0, done}, 32'h1);
            chk("mis", {31'h0, misaligned}, 32'h0);
        end
        chk("err", {31'h0, bus_error}, {31'h0, exp_err});
        chk("ld", load_data, exp_ld);
        @(negedge clk);
        chk("post_done", {31'h0, done}, 32'h0);
        chk("post_busy", {31'h0, busy}, 32'h0);
        chk("hold_ld", load_data, exp_ld);
        chk("hold_err", {31'h0, bus_error}, {31'h0, exp_err});
        chk("hold_mis", {31'h0, misaligned}, {31'h0, flt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.bus_ack = 1'b0;
        bif.bus_rdata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_flags", {30'h0, misaligned, bus_error}, 32'h0);
        chk("rst_req", {31'h0, bif.bus_req}, 32'h0);
        chk("rst_we", {31'h0, bif.bus_we}, 32'h0);
        chk("rst_addr", bif.bus_addr, 32'h0);
        chk("rst_be", {28'h0, bif.bus_byte_en}, 32'h0);
        chk("rst_wdata", bif.bus_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed scenarios
        access(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 32'h80FF_0000);
        chk("plan_sbyte", load_data, 32'hFFFF_FF80);
        access(1'b1, 2'b01, 1'b1, 32'h2002, 32'h0, 1, 32'h8001_1234);
        chk("plan_uhalf", load_data, 32'h0000_8001);
        access(1'b0, 2'b00, 1'b0, 32'h3001, 32'h0000_00AB, 3, 32'h0);
        chk("plan_store_ld", load_data, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h4002, 32'h0, 0, 32'h0);
        chk("plan_mis_word", {31'h0, misaligned}, 32'h1);
        access(1'b1, 2'b11, 1'b0, 32'h4000, 32'h0, 0, 32'h0);
        chk("plan_mis_rsvd", {31'h0, misaligned}, 32'h1);
        access(1'b1, 2'b10, 1'b0, 32'h5000, 32'h0, 99, 32'h0);
        chk("plan_timeout", {31'h0, bus_error}, 32'h1);
        access(1'b1, 2'b10, 1'b0, 32'h5004, 32'h0, T - 1, 32'hCAFE_F00D);
        chk("plan_ack_wins", {31'h0, bus_error}, 32'h0);
        chk("plan_ack_data", load_data, 32'hCAFE_F00D);

        // reset two cycles into REQ
        @(negedge clk);
        start = 1'b1; mp = '{op: 1'b1, access_size: 2'b10, read_unsigned: 1'b0};
        addr = 32'h6000;
        @(negedge clk);
        start = 1'b0;
        chk("mid_req1", {31'h0, bif.bus_req}, 32'h1);
        @(negedge clk);
        chk("mid_req2", {31'h0, bif.bus_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, bif.bus_req}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        chk("late_ack_done", {31'h0, done}, 32'h0);
        chk("late_ack_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("late_ack_done2", {31'h0, done}, 32'h0);
        access(1'b1, 2'b01, 1'b0, 32'h7000, 32'h0, 2, 32'h0000_F00F);
        chk("post_rst_ld", load_data, 32'hFFFF_F00F);

        // randomized accesses
        for (int i = 0; i < 80; i++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, T + 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
